// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: FSM encodings, reset defaults
// and the PC increment helper.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_WAIT = 2'b01,
        FS_DROP = 2'b10
    } fs_state_e;

    // Plain 32-bit wrap; no alignment check.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave). At most one request is outstanding.
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with a 1-entry skid buffer that catches a response
// arriving while ID is stalled.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        rsp_load,
    input  logic [31:0] rsp_instr,
    input  logic [31:0] rsp_pcadd4,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pcadd4,
    output logic        buf_valid
);

    logic [31:0] buf_instr;
    logic [31:0] buf_pcadd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer payload is reset along with its valid bit; it is a
            // single register pair, not a RAM, so the reset costs nothing and keeps X out.
            buf_valid  <= 1'b0;
            buf_instr  <= NOP_INSTR;
            buf_pcadd4 <= '0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pcadd4  <= '0;
        end else if (flush) begin
            buf_valid <= 1'b0;
            id_valid  <= 1'b0;
            id_instr  <= NOP_INSTR;
        end else if (stall) begin
            // ID holds; only a fresh response may land, and only in the buffer.
            if (rsp_load) begin
                buf_valid  <= 1'b1;
                buf_instr  <= rsp_instr;
                buf_pcadd4 <= rsp_pcadd4;
            end
        end else if (buf_valid) begin
            id_valid  <= 1'b1;
            id_instr  <= buf_instr;
            id_pcadd4 <= buf_pcadd4;
            buf_valid <= 1'b0;
        end else if (rsp_load) begin
            id_valid  <= 1'b1;
            id_instr  <= rsp_instr;
            id_pcadd4 <= rsp_pcadd4;
        end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, issues one instruction fetch at a time and
// feeds the IF/ID register; redirects arrive through NextPC/IFFlush.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           NextPC,
    input  logic                  IFFlush,
    input  logic                  Stall,
    output logic [31:0]           PCAdd4,
    if_fetch_unit_if.master       imem,
    output logic                  ID_Valid,
    output logic [31:0]           ID_Instr,
    output logic [31:0]           ID_PCAdd4
);

    fs_state_e   state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        buf_valid;
    logic        req_fire;
    logic        rsp_load;

    // Issuing in the cycle a response returns gives one fetch per cycle on a
    // 1-cycle memory while still keeping a single request outstanding.
    assign imem.imem_req_valid = !rst && !IFFlush && !Stall && !buf_valid &&
                                 (state == FS_IDLE || imem.imem_rsp_valid);
    assign imem.imem_addr      = pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_load            = (state == FS_WAIT) && imem.imem_rsp_valid;
    assign PCAdd4              = pc_plus4(pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
            state  <= FS_IDLE;
        end else if (IFFlush) begin
            pc <= NextPC;
            // A fetch still in flight must have its response thrown away.
            if (state != FS_IDLE && !imem.imem_rsp_valid) begin
                state <= FS_DROP;
            end else begin
                state <= FS_IDLE;
            end
        end else if (req_fire) begin
            req_pc <= pc;
            pc     <= NextPC;
            state  <= FS_WAIT;
        end else if (imem.imem_rsp_valid && state != FS_IDLE) begin
            state <= FS_IDLE;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .flush      (IFFlush),
        .stall      (Stall),
        .rsp_load   (rsp_load),
        .rsp_instr  (imem.imem_rsp_data),
        .rsp_pcadd4 (pc_plus4(req_pc)),
        .id_valid   (ID_Valid),
        .id_instr   (ID_Instr),
        .id_pcadd4  (ID_PCAdd4),
        .buf_valid  (buf_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a transaction-level model (queues of
// outstanding fetches and buffered responses) is checked every cycle.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] NextPC = '0;
    logic        IFFlush = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] PCAdd4;
    logic        ID_Valid;
    logic [31:0] ID_Instr;
    logic [31:0] ID_PCAdd4;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .NextPC    (NextPC),
        .IFFlush   (IFFlush),
        .Stall     (Stall),
        .PCAdd4    (PCAdd4),
        .imem      (imem),
        .ID_Valid  (ID_Valid),
        .ID_Instr  (ID_Instr),
        .ID_PCAdd4 (ID_PCAdd4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a;
    endfunction

    // Memory model state (stimulus side).
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    // Reference model: outstanding fetches, pending buffered responses, ID contents.
    typedef struct {
        logic [31:0] addr;
        bit          keep;
    } fetch_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcadd4;
    } ent_t;

    fetch_t      m_out[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc        = RESET_PC_DEF;
    bit          m_id_valid  = 1'b0;
    logic [31:0] m_id_instr  = NOP_INSTR_DEF;
    logic [31:0] m_id_pcadd4 = '0;
    bit          exp_req;
    bit          deliver;
    ent_t        d;
    fetch_t      f;

    always @(negedge clk) begin
        exp_req = !rst && !IFFlush && !Stall && m_buf.size() == 0 &&
                  (m_out.size() == 0 || imem.imem_rsp_valid);
        check("req_valid", {31'b0, imem.imem_req_valid}, {31'b0, exp_req});
        if (exp_req) check("req_addr", imem.imem_addr, m_pc);
        check("pcadd4", PCAdd4, m_pc + 32'd4);
        check("id_valid", {31'b0, ID_Valid}, {31'b0, m_id_valid});
        check("id_instr", ID_Instr, m_id_instr);
        if (m_id_valid) check("id_pcadd4", ID_PCAdd4, m_id_pcadd4);

        if (rst) begin
            m_pc        = RESET_PC_DEF;
            m_out.delete();
            m_buf.delete();
            m_id_valid  = 1'b0;
            m_id_instr  = NOP_INSTR_DEF;
            m_id_pcadd4 = '0;
        end else if (IFFlush) begin
            m_pc       = NextPC;
            m_id_valid = 1'b0;
            m_id_instr = NOP_INSTR_DEF;
            m_buf.delete();
            if (m_out.size() != 0) begin
                if (imem.imem_rsp_valid) void'(m_out.pop_front());
                else m_out[0].keep = 1'b0;
            end
        end else begin
            deliver = 1'b0;
            if (imem.imem_rsp_valid && m_out.size() != 0) begin
                f = m_out.pop_front();
                if (f.keep) begin
                    deliver  = 1'b1;
                    d.instr  = imem.imem_rsp_data;
                    d.pcadd4 = f.addr + 32'd4;
                end
            end
            if (Stall) begin
                if (deliver) m_buf.push_back(d);
            end else begin
                if (m_buf.size() != 0) begin
                    d = m_buf.pop_front();
                    deliver = 1'b1;
                end
                if (deliver) begin
                    m_id_valid  = 1'b1;
                    m_id_instr  = d.instr;
                    m_id_pcadd4 = d.pcadd4;
                end else begin
                    m_id_valid = 1'b0;
                    m_id_instr = NOP_INSTR_DEF;
                end
            end
            if (exp_req && imem.imem_req_ready) begin
                m_out.push_back('{addr: m_pc, keep: 1'b1});
                m_pc = NextPC;
            end
        end
    end

    // One clock cycle: drive inputs, act as next-PC selector and memory, sample at negedge.
    task automatic tick(input bit st, input bit fl, input logic [31:0] tgt, input bit rdy,
                        output bit rv, output logic [31:0] ad);
        bit acc;
        bit given;
        Stall = st;
        IFFlush = fl;
        imem.imem_req_ready = rdy;
        imem.imem_rsp_valid = !rst && mem_pend && mem_cnt == 0;
        imem.imem_rsp_data  = mem_pend ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        #1;
        NextPC = fl ? tgt : PCAdd4;
        @(negedge clk);
        rv    = imem.imem_req_valid;
        ad    = imem.imem_addr;
        acc   = rv && rdy;
        given = imem.imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (given) mem_pend = 1'b0;
            else if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (acc) begin
                mem_pend = 1'b1;
                mem_addr = ad;
                mem_cnt  = mem_lat - 1;
            end
        end
    endtask

    bit          rv;
    logic [31:0] ad;

    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        rst = 1'b1;
        tick(0, 0, 0, 1, rv, ad);
        tick(0, 0, 0, 1, rv, ad);
        check("rst id_valid", {31'b0, ID_Valid}, 32'd0);
        check("rst pcadd4", PCAdd4, 32'h3004);
        rst = 1'b0;

        // Back-to-back fetch on a 1-cycle memory.
        tick(0, 0, 0, 1, rv, ad);
        check("A0 req", {31'b0, rv}, 32'd1);
        check("A0 addr", ad, 32'h3000);
        tick(0, 0, 0, 1, rv, ad);
        check("A1 addr", ad, 32'h3004);
        check("A1 id_valid", {31'b0, ID_Valid}, 32'd1);
        check("A1 id_pcadd4", ID_PCAdd4, 32'h3004);
        check("A1 id_instr", ID_Instr, ~32'h3000);
        tick(0, 0, 0, 1, rv, ad);
        check("A2 addr", ad, 32'h3008);
        check("A2 id_pcadd4", ID_PCAdd4, 32'h3008);
        tick(0, 0, 0, 1, rv, ad);
        check("A3 addr", ad, 32'h300C);
        check("A3 id_pcadd4", ID_PCAdd4, 32'h300C);

        // Stall for 3 cycles while the 0x300C response arrives.
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 1, rv, ad);
            check("stall req", {31'b0, rv}, 32'd0);
            check("stall id_pcadd4", ID_PCAdd4, 32'h300C);
            check("stall buf_valid", {31'b0, dut.buf_valid}, 32'd1);
        end
        tick(0, 0, 0, 1, rv, ad);
        check("unstall req", {31'b0, rv}, 32'd0);
        check("unstall id_pcadd4", ID_PCAdd4, 32'h3010);
        check("unstall id_instr", ID_Instr, ~32'h300C);
        check("unstall buf_valid", {31'b0, dut.buf_valid}, 32'd0);
        tick(0, 0, 0, 1, rv, ad);
        check("A8 addr", ad, 32'h3010);
        check("A8 id_valid", {31'b0, ID_Valid}, 32'd0);
        tick(0, 0, 0, 1, rv, ad);
        check("A9 id_pcadd4", ID_PCAdd4, 32'h3014);

        // Flush in WAIT with the response in the same cycle.
        tick(0, 1, 32'h3080, 1, rv, ad);
        check("flushrsp state", 32'(dut.state), 32'(FS_IDLE));
        check("flushrsp pcadd4", PCAdd4, 32'h3084);
        check("flushrsp id_valid", {31'b0, ID_Valid}, 32'd0);
        mem_lat = 3;
        tick(0, 0, 0, 1, rv, ad);
        check("A11 addr", ad, 32'h3080);

        // Flush in WAIT with no response: the late response is dropped.
        tick(0, 1, 32'h3040, 1, rv, ad);
        check("flush state", 32'(dut.state), 32'(FS_DROP));
        check("flush id_valid", {31'b0, ID_Valid}, 32'd0);
        tick(0, 0, 0, 1, rv, ad);
        check("drop wait req", {31'b0, rv}, 32'd0);
        check("drop wait state", 32'(dut.state), 32'(FS_DROP));
        mem_lat = 1;
        tick(0, 0, 0, 1, rv, ad);
        check("drop addr", ad, 32'h3040);
        check("drop id_valid", {31'b0, ID_Valid}, 32'd0);
        tick(0, 0, 0, 1, rv, ad);
        check("A15 id_pcadd4", ID_PCAdd4, 32'h3044);
        check("A15 id_instr", ID_Instr, ~32'h3040);

        // PC wrap at the top of the address space.
        tick(0, 1, 32'hFFFF_FFFC, 1, rv, ad);
        check("wrap pcadd4", PCAdd4, 32'h0000_0000);
        tick(0, 0, 0, 1, rv, ad);
        check("wrap addr", ad, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1, rv, ad);
        check("wrap id_pcadd4", ID_PCAdd4, 32'h0000_0000);
        check("wrap id_instr", ID_Instr, 32'h0000_0003);

        // Memory not ready for 4 cycles after a fresh reset.
        rst = 1'b1;
        tick(0, 0, 0, 1, rv, ad);
        tick(0, 0, 0, 1, rv, ad);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, rv, ad);
            check("notready addr", ad, 32'h3000);
            check("notready pcadd4", PCAdd4, 32'h3004);
            check("notready id_valid", {31'b0, ID_Valid}, 32'd0);
        end
        tick(0, 0, 0, 1, rv, ad);
        tick(0, 0, 0, 1, rv, ad);
        check("B5 id_pcadd4", ID_PCAdd4, 32'h3004);
        tick(1, 0, 0, 1, rv, ad);
        check("B6 buf_valid", {31'b0, dut.buf_valid}, 32'd1);

        // Reset with a buffered response pending.
        rst = 1'b1;
        tick(0, 0, 0, 1, rv, ad);
        check("midrst pcadd4", PCAdd4, 32'h3004);
        check("midrst buf_valid", {31'b0, dut.buf_valid}, 32'd0);
        check("midrst id_valid", {31'b0, ID_Valid}, 32'd0);
        check("midrst state", 32'(dut.state), 32'(FS_IDLE));
        rst = 1'b0;
        tick(0, 0, 0, 1, rv, ad);
        check("post rst addr", ad, 32'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
IF-stage fetch unit for the 5-stage forwarding pipeline. It holds the PC, issues one instruction-memory request at a time, and loads the IF/ID register. It also drives PCAdd4 into the next-PC selector. It consumes that selector's NextPC and IFFlush outputs, which make it the receiving end of the redirect interface. A 1-entry skid buffer absorbs a response that arrives while ID is stalled.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, ID_Instr value when ID_Valid=0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
NextPC  input  32  next PC from selector (equals PCAdd4 when no redirect)
IFFlush  input  1  redirect: load NextPC, squash IF/ID and in-flight fetch
Stall  input  1  hazard-unit stall: hold PC and IF/ID
PCAdd4  output  32  PC+4, combinational, to selector
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  fetch address (= PC)
imem_rsp_valid  input  1  response valid; in order, at most one outstanding
imem_rsp_data  input  32  fetched instruction
ID_Valid  output  1  IF/ID holds a real instruction
ID_Instr  output  32  IF/ID instruction
ID_PCAdd4  output  32  IF/ID address of instruction + 4

Behaviour:
- Reset: PC=RESET_PC; state=IDLE; buf_valid=0; ID_Valid=0; ID_Instr=NOP_INSTR; ID_PCAdd4=0; imem_req_valid=0 during the rst cycle. The memory is reset together with this block, so no stale response is expected after reset.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; its response will be used.
  - DROP: one request outstanding; its response will be discarded.
- The address of each accepted request is latched in req_pc.
- imem_req_valid = !rst && !IFFlush && !Stall && !buf_valid && (state==IDLE || imem_rsp_valid). This permits back-to-back fetch, one instruction per cycle with a 1-cycle memory.
- Handshake: a request is accepted when imem_req_valid && imem_req_ready. On acceptance: req_pc<=PC, PC<=NextPC, next state WAIT.
- IFFlush (priority below rst, above everything else):
  - PC<=NextPC; ID_Valid<=0; ID_Instr<=NOP_INSTR; buf_valid<=0.
  - WAIT without rsp -> DROP.
  - WAIT or DROP with rsp in the same cycle -> response discarded, state IDLE.
  - IDLE stays IDLE.
- DROP with rsp and no flush: the response is discarded. The state goes to WAIT if a new request is accepted that cycle, else IDLE.
- WAIT with rsp, no flush:
  - If Stall: data and req_pc+4 go to the buffer, buf_valid<=1.
  - Else: ID_Instr<=data, ID_PCAdd4<=req_pc+4, ID_Valid<=1.
  - The state goes to WAIT if a new request is accepted that cycle, else IDLE.
- Stall with no flush: PC, IF/ID and buffer are held, except that a response is captured into the buffer.
- No stall, no flush:
  - If buf_valid: buffer -> IF/ID, buf_valid<=0.
  - Else if a WAIT response arrives: response -> IF/ID.
  - Else: bubble (ID_Valid<=0, ID_Instr<=NOP_INSTR).
- The buffer never overflows. Issue is blocked while buf_valid=1 and while Stall=1, so at most one response is pending.
- PCAdd4 = PC+4 with 32-bit wrap (32'hFFFF_FFFC+4 = 0). No alignment check.

Decomposition:
- Shared package: state encodings (FS_IDLE=2'b00, FS_WAIT=2'b01, FS_DROP=2'b10), RESET_PC and NOP_INSTR defaults.
- One natural sub-module: if_id_reg. It holds the IF/ID register plus skid buffer, with load/hold/flush controls, and is instantiated once.

Test Plan:
- Reset, then 1-cycle memory always ready -> addresses 0x3000, 0x3004, 0x3008 on consecutive cycles. ID_PCAdd4 = 0x3004, 0x3008, ... with ID_Valid=1 every cycle from the 2nd cycle after reset release.
- IFFlush with NextPC=0x3040 while the 0x3008 fetch is outstanding and rsp is absent -> ID_Valid=0 next cycle, state DROP. The late rsp is discarded and the next request address is 0x3040.
- Stall held 3 cycles while rsp for 0x300C arrives -> no imem_req_valid during the stall, buffer captures the data, and IF/ID is unchanged. On stall release, ID_PCAdd4=0x3010 next cycle.
- IFFlush and imem_rsp_valid in the same cycle in WAIT -> response dropped, state IDLE, PC=NextPC, ID_Valid=0.
- imem_req_ready low for 4 cycles -> PC is held at 0x3000, imem_addr is stable, and ID_Valid=0 throughout.
- rst asserted mid-WAIT with buf_valid=1 -> next cycle PC=0x3000, buf_valid=0, ID_Valid=0, state IDLE.
